// File: rtl/attn_tile_sequencer.sv
// Attention tile sequencer: loads eight key/query rows into an 8x8 PE cluster,
// waits for the cluster, runs per-column FindMin, pulses the quantization
// stage, then hands a result to the consumer. Timeouts park the FSM in ERR.
module attn_tile_sequencer #(
  parameter int unsigned TIMEOUT   = 1023,
  parameter int unsigned QUANT_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] key_in_i,
  input  logic [127:0] query_in_i,
  output logic [127:0] pe_key_o,
  output logic [127:0] pe_query_o,
  output logic         pe_en_o,
  output logic         pe_clr_n_o,
  output logic [7:0]   pe_row_done_o,
  input  logic [63:0]  pe_dones_i,
  output logic [7:0]   min_start_o,
  input  logic [7:0]   min_done_i,
  output logic         quant_en_o,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         busy_o,
  output logic         err_o
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam int QW = ($clog2(QUANT_CYC + 1) > 1) ? $clog2(QUANT_CYC + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [QW-1:0] QUANT_LAST = QW'(QUANT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_MINSRCH, S_QUANT, S_OUTPUT, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     rowcnt_q, rowcnt_d;
  logic [7:0]     cap_q, cap_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [QW-1:0]  qcnt_q, qcnt_d;
  logic [127:0]   pe_key_q, pe_key_d;
  logic [127:0]   pe_query_q, pe_query_d;
  logic [7:0]     row_done_q, row_done_d;
  logic           live_q;

  logic start_acc;
  logic beat;
  logic timer_hit;

  assign start_acc = start_i && (state_q == S_IDLE || state_q == S_ERR);
  assign beat      = (state_q == S_LOAD) && in_valid_i;
  assign timer_hit = (timer_q == TIMER_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; completion is checked before the timeout so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_LOAD;
      S_LOAD:    if (in_valid_i && rowcnt_q == 3'd7) state_d = S_COMPUTE;
      S_COMPUTE: if (&pe_dones_i) state_d = S_MINSRCH;
                 else if (timer_hit) state_d = S_ERR;
      S_MINSRCH: if (&(cap_q | min_done_i)) state_d = S_QUANT;
                 else if (timer_hit) state_d = S_ERR;
      S_QUANT:   if (qcnt_q == QUANT_LAST) state_d = S_OUTPUT;
      S_OUTPUT:  if (res_ready_i) state_d = S_IDLE;
      S_ERR:     if (start_i) state_d = S_LOAD;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values: row capture, FindMin capture, wait timer, quant counter.
  always_comb begin
    rowcnt_d   = rowcnt_q;
    cap_d      = cap_q;
    timer_d    = '0;
    qcnt_d     = '0;
    pe_key_d   = pe_key_q;
    pe_query_d = pe_query_q;
    row_done_d = '0;
    if (start_acc) begin
      rowcnt_d = '0;
      cap_d    = '0;
    end
    if (beat) begin
      pe_key_d   = key_in_i;
      pe_query_d = query_in_i;
      row_done_d = 8'h01 << rowcnt_q;
      rowcnt_d   = rowcnt_q + 3'd1;
    end
    if (state_q == S_MINSRCH) cap_d = cap_q | min_done_i;
    else if (state_d == S_MINSRCH) cap_d = '0;
    if ((state_q == S_COMPUTE || state_q == S_MINSRCH) && state_d == state_q)
      timer_d = timer_q + TW'(1);
    if (state_q == S_QUANT && state_d == S_QUANT)
      qcnt_d = qcnt_q + QW'(1);
  end

  // Datapath registers; live_q holds the cluster in clear until the first edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rowcnt_q   <= '0;
      cap_q      <= '0;
      timer_q    <= '0;
      qcnt_q     <= '0;
      pe_key_q   <= '0;
      pe_query_q <= '0;
      row_done_q <= '0;
      live_q     <= 1'b0;
    end else begin
      rowcnt_q   <= rowcnt_d;
      cap_q      <= cap_d;
      timer_q    <= timer_d;
      qcnt_q     <= qcnt_d;
      pe_key_q   <= pe_key_d;
      pe_query_q <= pe_query_d;
      row_done_q <= row_done_d;
      live_q     <= 1'b1;
    end
  end

  // Output decode; the clear pulse coincides with the result handshake cycle.
  always_comb begin
    in_ready_o    = (state_q == S_LOAD);
    pe_key_o      = pe_key_q;
    pe_query_o    = pe_query_q;
    pe_row_done_o = row_done_q;
    pe_en_o       = !(state_q == S_IDLE || state_q == S_ERR);
    pe_clr_n_o    = live_q && (state_q != S_ERR) &&
                    !(state_q == S_OUTPUT && res_ready_i);
    min_start_o   = (state_q == S_MINSRCH) ? ~cap_q : 8'h00;
    quant_en_o    = (state_q == S_QUANT);
    res_valid_o   = (state_q == S_OUTPUT);
    busy_o        = (state_q != S_IDLE);
    err_o         = (state_q == S_ERR);
  end

endmodule

// File: doc/attn_tile_sequencer.md
ATTN_TILE_SEQUENCER -- requirements
Module: attn_tile_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1023, max cycles allowed in any wait state (COMPUTE, MINSRCH) before error.
REQ-002 Parameter QUANT_CYC, default 2, cycles quant_en is held high.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one tile run; sampled only in IDLE.
REQ-006 in_valid / in_ready  in / out  1 / 1  source handshake for one row beat.
REQ-007 key_in, query_in  in  128 / 128  one row of eight 16-bit key / query elements.
REQ-008 pe_key, pe_query  out  128 / 128  registered row driven to the 8x8 PE cluster.
REQ-009 pe_en  out  1  cluster enable.
REQ-010 pe_clr_n  out  1  cluster clear, active-low.
REQ-011 pe_row_done  out  8  one-hot row-valid strobe to the cluster.
REQ-012 pe_dones  in  64  per-PE calc-done flags, bit 8*row+col.
REQ-013 min_start  out  8  per-column FindMin start.
REQ-014 min_done  in  8  per-column FindMin done.
REQ-015 quant_en  out  1  enables the quantization/softmax stage.
REQ-016 res_valid / res_ready  out / in  1 / 1  result handshake to consumer.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, LOAD, COMPUTE, MINSRCH, QUANT, OUTPUT, ERR; encoding free.
REQ-020 IDLE: start=1 -> LOAD next cycle; clears err, row counter, min-done capture, timer; pe_clr_n=1, pe_en=1 from LOAD onward.
REQ-021 LOAD: in_ready=1; each cycle with in_valid=1 registers key_in/query_in to pe_key/pe_query and drives pe_row_done=1<<rowcnt for exactly that cycle; rowcnt increments 0..7.
REQ-022 LOAD: beat with rowcnt=7 -> COMPUTE; in_valid gaps stall without strobes; pe_key/pe_query hold last value.
REQ-023 in_ready=0 in every state other than LOAD.
REQ-024 COMPUTE: waits for &pe_dones=1 -> MINSRCH next cycle; partial done sets ignored.
REQ-025 MINSRCH: min_start=8'hFF on entry; bit c drops to 0 the cycle after min_done[c] is seen and stays 0; captures done bits sticky; all 8 captured -> QUANT.
REQ-026 min_done bits arriving in the same cycle are all captured; min_done on a column already captured is ignored.
REQ-027 QUANT: quant_en=1 for exactly QUANT_CYC cycles, then OUTPUT.
REQ-028 OUTPUT: res_valid=1 held until res_ready=1; on that cycle -> IDLE with pe_clr_n pulsed 0 for one cycle (cluster cleared for next tile).
REQ-029 res_ready ignored outside OUTPUT; start ignored outside IDLE.
REQ-030 Timer: 10-bit-or-wider counter reset on entry to COMPUTE and MINSRCH, increments each cycle there; reaching TIMEOUT -> ERR.
REQ-031 ERR: err=1, pe_en=0, pe_clr_n=0, min_start=0, busy=1; start=1 -> LOAD (err cleared, as REQ-020); otherwise stays.
REQ-032 Completion wins over timeout when both occur in the same cycle.

Reset
REQ-033 rst_n=0 asynchronously forces IDLE and: pe_key=pe_query=0, pe_en=0, pe_clr_n=0, pe_row_done=0, min_start=0, quant_en=0, in_ready=0, res_valid=0, busy=0, err=0, counters 0.
REQ-034 pe_clr_n remains 0 until the first cycle after rst_n release, then 1.
REQ-035 Reset mid-run abandons the tile; no output strobes appear on release until a new start.

Verification
REQ-036 Nominal: start, 8 back-to-back beats rows 0x0001..0x0008 -> pe_row_done 0x01..0x80 on consecutive cycles, pe_key tracks input one cycle late, in_ready drops after beat 8.
REQ-037 Stalled load: in_valid toggling 1/0 -> exactly 8 strobes over 16 cycles, no strobe on gap cycles.
REQ-038 Min staggering: min_done columns 3 then {0,7} together then rest -> min_start bits clear individually; QUANT entered only after last column; quant_en high exactly 2 cycles.
REQ-039 Backpressure: res_ready low 5 cycles in OUTPUT -> res_valid held 5+ cycles; one-cycle pe_clr_n=0 on the handshake cycle; busy=0 next cycle.
REQ-040 Timeout: pe_dones stuck at 64'h7FFF_FFFF_FFFF_FFFF, TIMEOUT=16 -> ERR after 16 COMPUTE cycles, err=1 sticky; new start clears err and re-enters LOAD.
REQ-041 Async reset asserted mid-MINSRCH -> all outputs reach REQ-033 values without a clock edge; no residual min_start after release.
